// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and state type for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bundle: request/done in, grant and mux selects out.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] grant;
    logic            s1;
    logic            s0;
    logic            busy;

    modport master (
        output req, done,
        input  grant, s1, s0, busy
    );

    modport slave (
        input  req, done,
        output grant, s1, s0, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_pick
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [NREQ-1:0]  onehot
);

    logic [SEL_W-1:0] pos;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = ptr + SEL_W'(k);
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
        onehot[idx] = any;
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sequencing a shared 4:1 mux; tenure ends on done, request drop or hold timeout.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic               clk,
    input logic               rst,
    mux4_rr_arbiter_if.slave  bus
);

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    ptr, ptr_nxt;
    logic [SEL_W-1:0]    sel, sel_nxt;
    logic [NREQ-1:0]     grant, grant_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;

    logic                pick_any;
    logic [SEL_W-1:0]    pick_idx;
    logic [NREQ-1:0]     pick_onehot;
    logic                release_now;

    rr_pick u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // sel doubles as the owner index while in GRANT
    assign release_now = bus.done || !bus.req[sel] || (HOLD_EN && (hold_cnt == HOLD_LAST));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        hold_nxt  = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_onehot;
                    sel_nxt   = pick_idx;
                    hold_nxt  = '0;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    grant_nxt = '0;
                    ptr_nxt   = sel + SEL_W'(1);
                    state_nxt = ST_IDLE;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.grant = grant;
    assign bus.s1    = sel[1];
    assign bus.s0    = sel[0];
    assign bus.busy  = (state == ST_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench: three arbiters (MAX_HOLD 16/4/0) against a tenure-level model, plus exhaustive rr_pick test.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if if16 ();
    mux4_rr_arbiter_if if4 ();
    mux4_rr_arbiter_if if0 ();

    assign if16.req = req;  assign if16.done = done;
    assign if4.req  = req;  assign if4.done  = done;
    assign if0.req  = req;  assign if0.done  = done;

    mux4_rr_arbiter #(.MAX_HOLD(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    mux4_rr_arbiter #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    mux4_rr_arbiter #(.MAX_HOLD(0))  dut0  (.clk(clk), .rst(rst), .bus(if0));

    logic [3:0] pick_req;
    logic [1:0] pick_ptr;
    logic       pick_any;
    logic [1:0] pick_idx;
    logic [3:0] pick_onehot;

    rr_pick u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    logic [3:0] d_grant [3];
    logic [1:0] d_sel   [3];
    logic       d_busy  [3];
    assign d_grant[0] = if16.grant; assign d_sel[0] = {if16.s1, if16.s0}; assign d_busy[0] = if16.busy;
    assign d_grant[1] = if4.grant;  assign d_sel[1] = {if4.s1,  if4.s0};  assign d_busy[1] = if4.busy;
    assign d_grant[2] = if0.grant;  assign d_sel[2] = {if0.s1,  if0.s0};  assign d_busy[2] = if0.busy;

    // Tenure-level model: owner (-1 = none), next-first pointer, cycles held so far, last select.
    int mh       [3] = '{16, 4, 0};
    int m_owner  [3] = '{-1, -1, -1};
    int m_ptr    [3] = '{0, 0, 0};
    int m_held   [3] = '{0, 0, 0};
    int m_sel    [3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owner[i] = -1;
            m_ptr[i]   = 0;
            m_held[i]  = 0;
            m_sel[i]   = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (m_owner[i] < 0) begin
                if (req != 4'b0000) begin
                    bit found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        int c = (m_ptr[i] + k) % 4;
                        if (!found && req[c]) begin
                            found      = 1'b1;
                            m_owner[i] = c;
                        end
                    end
                    m_sel[i]  = m_owner[i];
                    m_held[i] = 1;
                end
            end else if (done || !req[m_owner[i]] || (mh[i] != 0 && m_held[i] == mh[i])) begin
                m_ptr[i]   = (m_owner[i] + 1) % 4;
                m_owner[i] = -1;
            end else begin
                m_held[i]++;
            end
        end
    endtask

    always begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
        #1;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] eg;
            eg = (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
            chk($sformatf("cmp_grant[%0d]", i), 32'(d_grant[i]), 32'(eg));
            chk($sformatf("cmp_sel[%0d]", i),   32'(d_sel[i]),   32'(m_sel[i]));
            chk($sformatf("cmp_busy[%0d]", i),  32'(d_busy[i]),  32'(m_owner[i] >= 0));
        end
    end

    task automatic reset_all();
        @(negedge clk);
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;

        // exhaustive picker check
        for (int p = 0; p < 4; p++) begin
            for (int r = 0; r < 16; r++) begin
                logic [3:0] rv;
                int         first;
                logic [6:0] exp_v;
                rv = 4'(r);
                pick_req = rv;
                pick_ptr = 2'(p);
                #1;
                first = -1;
                for (int k = 3; k >= 0; k--)
                    if (rv[(p + k) % 4]) first = (p + k) % 4;
                exp_v = (first < 0) ? 7'b0 : {1'b1, 2'(first), 4'(1 << first)};
                chk($sformatf("rr_pick p=%0d r=%0h", p, r), 32'({pick_any, pick_idx, pick_onehot}), 32'(exp_v));
            end
        end

        reset_all();
        chk("reset_grant", 32'(if16.grant), 32'h0);
        chk("reset_sel",   32'({if16.s1, if16.s0}), 32'h0);
        chk("reset_busy",  32'(if16.busy), 32'h0);

        // done in 3rd grant cycle, then re-grant to 2 through the pointer wrap
        req = 4'b0100;
        @(posedge clk); #2;
        chk("t1_grant", 32'(if16.grant), 32'h4);
        chk("t1_sel",   32'({if16.s1, if16.s0}), 32'h2);
        @(posedge clk);
        @(posedge clk); #2;
        chk("t1_cyc3", 32'(if16.grant), 32'h4);
        @(negedge clk) done = 1'b1;
        @(posedge clk); #2;
        chk("t1_rel_grant", 32'(if16.grant), 32'h0);
        chk("t1_rel_busy",  32'(if16.busy), 32'h0);
        chk("t1_rel_sel",   32'({if16.s1, if16.s0}), 32'h2);
        @(negedge clk) done = 1'b0;
        @(posedge clk); #2;
        chk("t1_regrant", 32'(if16.grant), 32'h4);

        // all requesting with MAX_HOLD=4: 0,1,2,3,0 each 4 cycles plus a bubble
        reset_all();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            chk($sformatf("t2_grant%0d", k), 32'(if4.grant), 32'(1 << (k % 4)));
            chk($sformatf("t2_sel%0d", k),   32'({if4.s1, if4.s0}), 32'(k % 4));
            repeat (3) begin
                @(posedge clk); #2;
                chk($sformatf("t2_hold%0d", k), 32'(if4.grant), 32'(1 << (k % 4)));
            end
            @(posedge clk); #2;
            chk($sformatf("t2_gap%0d", k), 32'(if4.grant), 32'h0);
        end

        // owner 1 withdraws while 3 waits
        reset_all();
        req = 4'b1010;
        @(posedge clk); #2;
        chk("t3_grant1", 32'(if16.grant), 32'h2);
        @(negedge clk) req = 4'b1000;
        @(posedge clk); #2;
        chk("t3_drop", 32'(if16.grant), 32'h0);
        @(posedge clk); #2;
        chk("t3_grant3", 32'(if16.grant), 32'h8);
        chk("t3_sel3",   32'({if16.s1, if16.s0}), 32'h3);

        // no timeout: 300 cycles of continuous ownership
        reset_all();
        req = 4'b0001;
        @(posedge clk); #2;
        chk("t4_start", 32'(if0.grant), 32'h1);
        repeat (300) begin
            @(posedge clk); #2;
            chk("t4_hold", 32'(if0.grant), 32'h1);
        end

        // async reset mid-tenure with ptr moved to 2; pointer must restart at 0
        reset_all();
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk) done = 1'b1;
        @(posedge clk);
        @(negedge clk) done = 1'b0;
        @(posedge clk); #2;
        chk("t5_owner1", 32'(if16.grant), 32'h2);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(if16.grant), 32'h0);
        chk("t5_async_busy",  32'(if16.busy), 32'h0);
        chk("t5_async_sel",   32'({if16.s1, if16.s0}), 32'h0);
        req = 4'b0110;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #2;
        chk("t5_after_grant", 32'(if16.grant), 32'h2);
        chk("t5_after_sel",   32'({if16.s1, if16.s0}), 32'h1);

        // done while idle is ignored
        reset_all();
        done = 1'b1;
        @(posedge clk); #2;
        chk("t6_idle", 32'(if16.grant), 32'h0);
        @(negedge clk) req = 4'b0001;
        @(posedge clk); #2;
        chk("t6_grant", 32'(if16.grant), 32'h1);
        chk("t6_sel",   32'({if16.s1, if16.s0}), 32'h0);
        @(negedge clk) done = 1'b0;

        // randomized traffic, checked every cycle by the model
        reset_all();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 single-bit mux channel. Four requesters compete for the channel. The block grants one requester at a time and drives the mux select lines s1/s0 to match. Grant tenure ends on a done pulse, on request withdrawal, or on a hold-timeout, so no requester can starve the others.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per tenure; legal range 0..255; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  request vector; bit n is requester n, level-sensitive.
done  input  1  current owner releases the channel; sampled only in GRANT.
grant  output  4  one-hot grant, registered; all zero when no owner.
s1  output  1  mux select MSB, registered; equals owner index bit 1.
s0  output  1  mux select LSB, registered; equals owner index bit 0.
busy  output  1  high while in GRANT; equals the OR of grant.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, grant=4'b0000, s1=0, s0=0, busy=0, priority pointer ptr=0, hold_cnt=0.
- There are two states: IDLE and GRANT.
- IDLE:
  - If req is nonzero, select the first set bit scanning ptr, ptr+1, ... modulo 4.
  - At that clock edge: grant=onehot(winner), {s1,s0}=winner, busy=1, hold_cnt=0, next state GRANT.
  - Latency is one cycle from req sampled high to grant visible.
  - If req is zero, stay in IDLE. grant=0, and {s1,s0} holds the last owner index so the mux output stays stable.
  - done is ignored in IDLE.
- GRANT: the release condition is R = done OR NOT req[owner] OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
  - If R: at the edge grant=0, busy=0, ptr=(owner+1) mod 4 (2-bit wrap, 3 -> 0), {s1,s0} unchanged, next state IDLE.
  - Otherwise: hold_cnt increments (8-bit counter), and grant and {s1,s0} are unchanged.
  - With MAX_HOLD=N and no other release, grant is high for exactly N cycles.
- Every tenure is followed by at least one IDLE cycle with grant=0. This is a deliberate turnaround bubble before the select changes.
- Other requesters' req changes during GRANT have no effect.
- If done and a timeout occur in the same cycle: single release, same result.
- grant is always one-hot or zero, and {s1,s0} always equals the index of the set grant bit whenever busy=1.
- Reset asserted mid-tenure drops grant immediately (asynchronously). After reset release, the pointer restarts at 0.

Decomposition:
- Shared header/package: NREQ=4, SEL_W=2, HOLD_W=8, and the state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1.
- One combinational sub-module, rr_pick. Inputs: req[3:0] and ptr[1:0]. Outputs: any (1), idx[1:0] and onehot[3:0], giving the first set bit at or after ptr cyclically.
- Unit-test rr_pick exhaustively: 64 input combinations.

Test Plan:
- Reset, then req=4'b0100 held, done pulsed in the 3rd grant cycle -> grant=4'b0100 and {s1,s0}=2'b10 one cycle after req, grant high for exactly 3 cycles, then one idle cycle, then re-grant to requester 2 (ptr=3 wraps to 2).
- req=4'b1111 held, done=0, MAX_HOLD=4 -> grants go 0,1,2,3,0 in order, each high 4 cycles, each followed by a 1-cycle gap; {s1,s0} sequence 00,01,10,11,00.
- Owner 1 granted, req[1] dropped mid-tenure while req[3]=1 -> grant falls at the next edge, one idle cycle, then grant=4'b1000 with {s1,s0}=2'b11.
- MAX_HOLD=0 with req=4'b0001 held for 300 cycles and no done -> grant stays 4'b0001 throughout; the hold counter wrap has no effect.
- rst pulsed while grant=4'b0010 -> grant=0, busy=0 and {s1,s0}=00 immediately; after release with req=4'b0110, the first grant is requester 1 (ptr=0).
- done pulsed while IDLE with req=0, then req=4'b0001 -> done ignored; grant=4'b0001 one cycle after req rises.
